// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//
// Shared definitions for the MEM-stage data-memory access controller.
//
// Contents:
//   mem_state_t         - access FSM state encoding (IDLE, WAIT, ERR)
//   DEF_TIMEOUT_CYCLES  - default WAIT budget before an access is abandoned
//   DEF_TMO_W           - default width of the wait counter
//   word_addr()         - forces a byte address onto its word boundary
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 64;
    localparam int DEF_TMO_W          = 8;

    // Data memory is word addressed on the bus; the two low byte-offset bits
    // are always presented as zero.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage : mips_pkg

// File: rtl/dmem_wait_timer.sv
// -----------------------------------------------------------------------------
// dmem_wait_timer
//
// Wait-cycle counter for an outstanding data-memory access. The counter is
// cleared when the controller enters WAIT and advances on every WAIT cycle.
// expired_o is raised during the WAIT cycle in which the counter steps onto
// TIMEOUT_CYCLES-1, i.e. the last cycle the controller is allowed to keep
// waiting. Together with the stalled request cycle in IDLE, the controller
// therefore stalls for exactly TIMEOUT_CYCLES cycles before giving up.
//
// Parameters:
//   TMO_W           - counter width; must hold TIMEOUT_CYCLES
//   TIMEOUT_CYCLES  - wait budget (>= 2)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-low reset
//   clr_i      in   clear counter to zero (takes priority over inc_i)
//   inc_i      in   advance counter by one
//   expired_o  out  counter is at its limit in an advancing cycle
// -----------------------------------------------------------------------------
module dmem_wait_timer #(
    parameter int TMO_W          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    // The count value held during the final permitted WAIT cycle; its
    // increment would land on TIMEOUT_CYCLES-1.
    localparam logic [TMO_W-1:0] LAST_CNT = TMO_W'(TIMEOUT_CYCLES - 2);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = inc_i & (cnt_q == LAST_CNT);

endmodule : dmem_wait_timer

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM-stage data-memory access controller between the EX/MEM and MEM/WB
// registers. Issues load/store requests, stalls the front of the pipeline
// while an access is outstanding, and presents the load data plus the
// pass-through write-back controls to MEM/WB. MEM/WB has no enable, so every
// cycle in which the access is not complete is turned into a bubble by
// forcing RegWrite_out low.
//
// Handshake: dmem_req is the request valid and dmem_ready the completion.
// An access completes in the cycle where both are high; the request fields
// (dmem_addr, dmem_we, dmem_wdata) stay stable until then because stall_M
// freezes EX/MEM. A dmem_ready seen while dmem_req is low is ignored.
//
// Parameters:
//   TIMEOUT_CYCLES  - stalled cycles before an access is abandoned (>= 2)
//   TMO_W           - wait counter width; must hold TIMEOUT_CYCLES
//
// Optional feature (macro MEM_ALIGN_CHECK_EN):
//   defined     - a misaligned access issues no request, pulses misalign_M
//                 and retires as a bubble without stalling
//   undefined   - misalign_M is absent and the low address bits are dropped
//
// Ports:
//   clk, rst                    clock / asynchronous active-low reset
//   ALUResult_M, WriteData_M    byte address (or result) and store data
//   MemRead_M, MemWrite_M       access type (both high is treated as a read)
//   writereg_M, RegWrite_M,
//   MemtoReg_M                  write-back controls from EX/MEM
//   dmem_req, dmem_we,
//   dmem_addr, dmem_wdata       request to data memory
//   dmem_ready, dmem_rdata      completion and load data from data memory
//   ReadData_M, ALUResult_out,
//   writereg_out, RegWrite_out,
//   MemtoReg_out                to MEM/WB
//   stall_M                     freeze PC, IF/ID, ID/EX, EX/MEM
//   bus_err_M                   one-cycle timeout pulse
//   state_dbg_o                 current access FSM state
//   misalign_M                  misaligned-access pulse (MEM_ALIGN_CHECK_EN)
// -----------------------------------------------------------------------------
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TMO_W          = DEF_TMO_W
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] ALUResult_M,
    input  logic [31:0] WriteData_M,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [4:0]  writereg_M,
    input  logic        RegWrite_M,
    input  logic        MemtoReg_M,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,

    output logic [31:0] ReadData_M,
    output logic [31:0] ALUResult_out,
    output logic [4:0]  writereg_out,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,

    output logic        stall_M,
    output logic        bus_err_M,
    output mem_state_t  state_dbg_o
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        misalign_M
`endif
);

    mem_state_t  state_q;
    mem_state_t  state_d;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    logic        access;
    logic        misaligned;
    logic        req_int;
    logic        stall_int;
    logic        err_int;
    logic        misalign_int;
    logic        timer_clr;
    logic        timer_inc;
    logic        timer_expired;
    logic        ready_eff;

    assign access = MemRead_M | MemWrite_M;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = access & (ALUResult_M[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Wait counter
    // ---------------------------------------------------------------------
    dmem_wait_timer #(
        .TMO_W          (TMO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (timer_clr),
        .inc_i     (timer_inc),
        .expired_o (timer_expired)
    );

    // ---------------------------------------------------------------------
    // Access FSM: next state and per-state outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        req_int      = 1'b0;
        stall_int    = 1'b0;
        err_int      = 1'b0;
        misalign_int = 1'b0;
        timer_clr    = 1'b0;
        timer_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                misalign_int = misaligned;
                req_int      = access & ~misaligned;
                // Zero-wait accesses complete here without leaving IDLE.
                if (req_int && !dmem_ready) begin
                    stall_int = 1'b1;
                    timer_clr = 1'b1;
                    state_d   = WAIT;
                end
            end

            WAIT: begin
                req_int   = 1'b1;
                timer_inc = 1'b1;
                stall_int = access & ~dmem_ready;
                // A ready arriving in the limit cycle still completes.
                if (dmem_ready) begin
                    state_d = IDLE;
                end else if (timer_expired) begin
                    state_d = ERR;
                end
            end

            ERR: begin
                // Release the pipeline; the faulting instruction retires
                // as a bubble.
                err_int = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // While reset is asserted the abandoned request and any stall are
    // withdrawn at once, independent of what EX/MEM still presents.
    assign dmem_req  = req_int & rst;
    assign stall_M   = stall_int & rst;
    assign bus_err_M = err_int;

    // ---------------------------------------------------------------------
    // Request fields
    // ---------------------------------------------------------------------
    assign dmem_we    = MemWrite_M & ~MemRead_M;
    assign dmem_addr  = word_addr(ALUResult_M);
    assign dmem_wdata = WriteData_M;

    // ---------------------------------------------------------------------
    // Load data: live word on completion, last captured word otherwise
    // ---------------------------------------------------------------------
    assign ready_eff = dmem_ready & dmem_req;

    always_comb begin
        rdata_d = rdata_q;
        if (ready_eff) begin
            rdata_d = dmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign ReadData_M = ready_eff ? dmem_rdata : rdata_q;

    // ---------------------------------------------------------------------
    // MEM/WB pass-through; bubble whenever the instruction cannot retire
    // ---------------------------------------------------------------------
    assign ALUResult_out = ALUResult_M;
    assign writereg_out  = writereg_M;
    assign MemtoReg_out  = MemtoReg_M;
    assign RegWrite_out  = RegWrite_M & ~stall_M & ~err_int & ~misalign_int;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_M = misalign_int;
`endif

    assign state_dbg_o = state_q;

endmodule : mem_access_stage

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    import mips_pkg::*;

    localparam int TMO = 8;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] ALUResult_M, WriteData_M, dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] ReadData_M, ALUResult_out;
    logic        MemRead_M, MemWrite_M, RegWrite_M, MemtoReg_M;
    logic [4:0]  writereg_M, writereg_out;
    logic        dmem_req, dmem_we, dmem_ready;
    logic        RegWrite_out, MemtoReg_out, stall_M, bus_err_M;
    mem_state_t  state_dbg_o;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_M;
`endif

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ALUResult_M  (ALUResult_M),
        .WriteData_M  (WriteData_M),
        .MemRead_M    (MemRead_M),
        .MemWrite_M   (MemWrite_M),
        .writereg_M   (writereg_M),
        .RegWrite_M   (RegWrite_M),
        .MemtoReg_M   (MemtoReg_M),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .ReadData_M   (ReadData_M),
        .ALUResult_out(ALUResult_out),
        .writereg_out (writereg_out),
        .RegWrite_out (RegWrite_out),
        .MemtoReg_out (MemtoReg_out),
        .stall_M      (stall_M),
        .bus_err_M    (bus_err_M),
        .state_dbg_o  (state_dbg_o)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misalign_M   (misalign_M)
`endif
    );

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic clear_inputs();
        ALUResult_M = '0; WriteData_M = '0; MemRead_M = 1'b0; MemWrite_M = 1'b0;
        writereg_M = '0; RegWrite_M = 1'b0; MemtoReg_M = 1'b0;
        dmem_ready = 1'b0; dmem_rdata = '0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd);
        clear_inputs();
        MemRead_M = 1'b1; ALUResult_M = addr; writereg_M = rd;
        RegWrite_M = 1'b1; MemtoReg_M = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        #3;
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
        total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall_M); end
        total++; if (bus_err_M !== 1'b0) begin bad++; $display("FAIL rst_buserr got=%b exp=0", bus_err_M); end
        total++; if (ReadData_M !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", ReadData_M); end
        total++; if (state_dbg_o !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg_o, IDLE); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_zero_wait_load();
        @(posedge clk); #1;
        drive_load(32'h100, 5'd5);
        dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL zw_req got=%b exp=1", dmem_req); end
        total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL zw_we got=%b exp=0", dmem_we); end
        total++; if (dmem_addr !== 32'h100) begin bad++; $display("FAIL zw_addr got=%h exp=00000100", dmem_addr); end
        total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL zw_stall got=%b exp=0", stall_M); end
        total++; if (ReadData_M !== 32'hDEADBEEF) begin bad++; $display("FAIL zw_rdata got=%h exp=deadbeef", ReadData_M); end
        total++; if (RegWrite_out !== 1'b1) begin bad++; $display("FAIL zw_regwrite got=%b exp=1", RegWrite_out); end
        total++; if (MemtoReg_out !== 1'b1) begin bad++; $display("FAIL zw_memtoreg got=%b exp=1", MemtoReg_out); end
        total++; if (writereg_out !== 5'd5) begin bad++; $display("FAIL zw_writereg got=%0d exp=5", writereg_out); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        total++; if (state_dbg_o !== IDLE) begin bad++; $display("FAIL zw_state got=%0d exp=%0d", state_dbg_o, IDLE); end
        total++; if (ReadData_M !== 32'hDEADBEEF) begin bad++; $display("FAIL zw_hold got=%h exp=deadbeef", ReadData_M); end
    endtask

    task automatic test_store_wait();
        int stalls = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                clear_inputs();
                MemWrite_M = 1'b1; ALUResult_M = 32'h40; WriteData_M = 32'h12345678;
            end
            dmem_ready = (k == 3);
            @(negedge clk);
            if (stall_M === 1'b1) stalls++;
            total++; if (stall_M !== (k < 3)) begin bad++; $display("FAIL sw_stall k=%0d got=%b exp=%b", k, stall_M, (k < 3)); end
            total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL sw_req k=%0d got=%b exp=1", k, dmem_req); end
            total++; if (dmem_we !== 1'b1) begin bad++; $display("FAIL sw_we k=%0d got=%b exp=1", k, dmem_we); end
            total++; if (dmem_addr !== 32'h40) begin bad++; $display("FAIL sw_addr k=%0d got=%h exp=00000040", k, dmem_addr); end
            total++; if (dmem_wdata !== 32'h12345678) begin bad++; $display("FAIL sw_wdata k=%0d got=%h exp=12345678", k, dmem_wdata); end
            total++; if (RegWrite_out !== 1'b0) begin bad++; $display("FAIL sw_regwrite k=%0d got=%b exp=0", k, RegWrite_out); end
        end
        total++; if (stalls != 3) begin bad++; $display("FAIL sw_stall_count got=%0d exp=3", stalls); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        total++; if (state_dbg_o !== IDLE) begin bad++; $display("FAIL sw_state got=%0d exp=%0d", state_dbg_o, IDLE); end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < TMO; k++) begin
            @(posedge clk); #1;
            if (k == 0) drive_load(32'h200, 5'd7);
            @(negedge clk);
            total++; if (stall_M !== 1'b1) begin bad++; $display("FAIL tmo_stall k=%0d got=%b exp=1", k, stall_M); end
            total++; if (bus_err_M !== 1'b0) begin bad++; $display("FAIL tmo_buserr_early k=%0d got=%b exp=0", k, bus_err_M); end
            total++; if (RegWrite_out !== 1'b0) begin bad++; $display("FAIL tmo_regwrite k=%0d got=%b exp=0", k, RegWrite_out); end
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (state_dbg_o !== ERR) begin bad++; $display("FAIL tmo_state_err got=%0d exp=%0d", state_dbg_o, ERR); end
        total++; if (bus_err_M !== 1'b1) begin bad++; $display("FAIL tmo_buserr got=%b exp=1", bus_err_M); end
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL tmo_req got=%b exp=0", dmem_req); end
        total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL tmo_stall_err got=%b exp=0", stall_M); end
        total++; if (RegWrite_out !== 1'b0) begin bad++; $display("FAIL tmo_regwrite_err got=%b exp=0", RegWrite_out); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        total++; if (bus_err_M !== 1'b0) begin bad++; $display("FAIL tmo_buserr_after got=%b exp=0", bus_err_M); end
        total++; if (state_dbg_o !== IDLE) begin bad++; $display("FAIL tmo_state_idle got=%0d exp=%0d", state_dbg_o, IDLE); end
    endtask

    task automatic test_ready_at_limit();
        for (int k = 0; k < TMO; k++) begin
            @(posedge clk); #1;
            if (k == 0) drive_load(32'h204, 5'd8);
            if (k == TMO - 1) begin dmem_ready = 1'b1; dmem_rdata = 32'h5A5A5A5A; end
            @(negedge clk);
            total++; if (stall_M !== (k < TMO - 1)) begin bad++; $display("FAIL lim_stall k=%0d got=%b exp=%b", k, stall_M, (k < TMO - 1)); end
        end
        total++; if (RegWrite_out !== 1'b1) begin bad++; $display("FAIL lim_regwrite got=%b exp=1", RegWrite_out); end
        total++; if (ReadData_M !== 32'h5A5A5A5A) begin bad++; $display("FAIL lim_rdata got=%h exp=5a5a5a5a", ReadData_M); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        total++; if (state_dbg_o !== IDLE) begin bad++; $display("FAIL lim_state got=%0d exp=%0d", state_dbg_o, IDLE); end
        total++; if (bus_err_M !== 1'b0) begin bad++; $display("FAIL lim_buserr got=%b exp=0", bus_err_M); end
    endtask

    task automatic test_reset_in_wait();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (k == 0) drive_load(32'h300, 5'd4);
            @(negedge clk);
        end
        total++; if (state_dbg_o !== WAIT) begin bad++; $display("FAIL rw_state_wait got=%0d exp=%0d", state_dbg_o, WAIT); end
        total++; if (stall_M !== 1'b1) begin bad++; $display("FAIL rw_stall_before got=%b exp=1", stall_M); end
        #2 rst = 1'b0;
        #1;
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rw_req got=%b exp=0", dmem_req); end
        total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL rw_stall got=%b exp=0", stall_M); end
        total++; if (state_dbg_o !== IDLE) begin bad++; $display("FAIL rw_state got=%0d exp=%0d", state_dbg_o, IDLE); end
        total++; if (ReadData_M !== 32'h0) begin bad++; $display("FAIL rw_rdata_clr got=%h exp=0", ReadData_M); end
        @(posedge clk); #1;
        rst = 1'b1;
        drive_load(32'h304, 5'd6);
        @(negedge clk);
        total++; if (stall_M !== 1'b1) begin bad++; $display("FAIL rw_new_stall got=%b exp=1", stall_M); end
        @(posedge clk); #1;
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL rw_new_done got=%b exp=0", stall_M); end
        total++; if (RegWrite_out !== 1'b1) begin bad++; $display("FAIL rw_new_regwrite got=%b exp=1", RegWrite_out); end
        total++; if (ReadData_M !== 32'hCAFEF00D) begin bad++; $display("FAIL rw_new_rdata got=%h exp=cafef00d", ReadData_M); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (k == 0) drive_load(32'h104, 5'd9);
            if (k == 2) begin dmem_ready = 1'b1; dmem_rdata = 32'h0BADF00D; end
            @(negedge clk);
            total++; if (stall_M !== (k < 2)) begin bad++; $display("FAIL b2b_stall k=%0d got=%b exp=%b", k, stall_M, (k < 2)); end
        end
        total++; if (RegWrite_out !== 1'b1) begin bad++; $display("FAIL b2b_lw_regwrite got=%b exp=1", RegWrite_out); end
        total++; if (ReadData_M !== 32'h0BADF00D) begin bad++; $display("FAIL b2b_lw_rdata got=%h exp=0badf00d", ReadData_M); end
        @(posedge clk); #1;
        clear_inputs();
        RegWrite_M = 1'b1; ALUResult_M = 32'h55; writereg_M = 5'd3;
        @(negedge clk);
        total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL b2b_add_stall got=%b exp=0", stall_M); end
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL b2b_add_req got=%b exp=0", dmem_req); end
        total++; if (RegWrite_out !== 1'b1) begin bad++; $display("FAIL b2b_add_regwrite got=%b exp=1", RegWrite_out); end
        total++; if (ALUResult_out !== 32'h55) begin bad++; $display("FAIL b2b_add_alu got=%h exp=00000055", ALUResult_out); end
        total++; if (writereg_out !== 5'd3) begin bad++; $display("FAIL b2b_add_rd got=%0d exp=3", writereg_out); end
        total++; if (MemtoReg_out !== 1'b0) begin bad++; $display("FAIL b2b_add_memtoreg got=%b exp=0", MemtoReg_out); end
        total++; if (ReadData_M !== 32'h0BADF00D) begin bad++; $display("FAIL b2b_add_hold got=%h exp=0badf00d", ReadData_M); end
    endtask

    task automatic test_ignored_ready();
        @(posedge clk); #1;
        clear_inputs();
        dmem_ready = 1'b1; dmem_rdata = 32'h11111111;
        @(negedge clk);
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL ign_req got=%b exp=0", dmem_req); end
        total++; if (ReadData_M !== 32'h0BADF00D) begin bad++; $display("FAIL ign_rdata got=%h exp=0badf00d", ReadData_M); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        total++; if (ReadData_M !== 32'h0BADF00D) begin bad++; $display("FAIL ign_hold got=%h exp=0badf00d", ReadData_M); end
    endtask

    task automatic test_illegal_both();
        @(posedge clk); #1;
        drive_load(32'h80, 5'd2);
        MemWrite_M = 1'b1;
        dmem_ready = 1'b1; dmem_rdata = 32'h00000022;
        @(negedge clk);
        total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL both_req got=%b exp=1", dmem_req); end
        total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL both_we got=%b exp=0", dmem_we); end
        total++; if (ReadData_M !== 32'h22) begin bad++; $display("FAIL both_rdata got=%h exp=00000022", ReadData_M); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_misalign();
        @(posedge clk); #1;
        drive_load(32'h102, 5'd10);
        dmem_ready = 1'b1; dmem_rdata = 32'h33333333;
        @(negedge clk);
        total++; if (stall_M !== 1'b0) begin bad++; $display("FAIL mis_stall got=%b exp=0", stall_M); end
`ifdef MEM_ALIGN_CHECK_EN
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%b exp=0", dmem_req); end
        total++; if (misalign_M !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", misalign_M); end
        total++; if (RegWrite_out !== 1'b0) begin bad++; $display("FAIL mis_regwrite got=%b exp=0", RegWrite_out); end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        total++; if (misalign_M !== 1'b0) begin bad++; $display("FAIL mis_flag_after got=%b exp=0", misalign_M); end
        total++; if (state_dbg_o !== IDLE) begin bad++; $display("FAIL mis_state got=%0d exp=%0d", state_dbg_o, IDLE); end
`else
        total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL mis_req got=%b exp=1", dmem_req); end
        total++; if (dmem_addr !== 32'h100) begin bad++; $display("FAIL mis_addr got=%h exp=00000100", dmem_addr); end
        total++; if (RegWrite_out !== 1'b1) begin bad++; $display("FAIL mis_regwrite got=%b exp=1", RegWrite_out); end
        total++; if (ReadData_M !== 32'h33333333) begin bad++; $display("FAIL mis_rdata got=%h exp=33333333", ReadData_M); end
        @(posedge clk); #1;
        clear_inputs();
`endif
    endtask

    // ---------------------------------------------------------------------
    // Sequence and report
    // ---------------------------------------------------------------------
    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_wait();
        test_timeout();
        test_ready_at_limit();
        test_reset_in_wait();
        test_back_to_back();
        test_ignored_ready();
        test_illegal_both();
        test_misalign();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_access_stage
